// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
//    rx_state_t       : receiver FSM states
//    UART_BAUD_CYCLES : clk cycles per bit, shared with the transmitter
//    UART_DATA_BITS   : data bits per frame
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   localparam int UART_BAUD_CYCLES = 44;
   localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: 2-flop synchronizer with reset-to-1 and falling-edge detect.
//    clk     : system clock
//    rst     : asynchronous active-high reset
//    async_i : asynchronous input, idles high
//    sync_o  : synchronized level
//    fall_o  : synchronized level went 1 -> 0 this cycle
module rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o,
   output logic fall_o
);
   logic meta_q, sync_q, prev_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) {meta_q, sync_q, prev_q} <= 3'b111;
      else {meta_q, sync_q, prev_q} <= {async_i, meta_q, sync_q};
   assign sync_o = sync_q;
   assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling each bit at mid-period.
//    clk     : system clock
//    rst     : asynchronous active-high reset
//    RX      : asynchronous serial line, idles high
//    clr_rdy : consumer acknowledge, clears rdy and ovr_err
//    rx_data : last correctly framed byte
//    rdy     : rx_data valid and not yet consumed
//    frm_err : one-cycle pulse on a low stop bit
//    ovr_err : sticky, a byte completed while rdy was still set
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_CYCLES = UART_BAUD_CYCLES,
   parameter int HALF_CYCLES = BAUD_CYCLES / 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      RX,
   input  logic                      clr_rdy,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rdy,
   output logic                      frm_err,
   output logic                      ovr_err
);
   localparam int BW = $clog2(BAUD_CYCLES);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CYCLES - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(HALF_CYCLES - 1);
   localparam logic [3:0] BITS_LAST = 4'(UART_DATA_BITS - 1);
   logic rx_s, fall;
   rx_state_t state_q;
   logic [BW-1:0] baud_q;
   logic [3:0] bit_q;
   logic [UART_DATA_BITS-1:0] shift_q, data_q;
   logic rdy_q, frm_q, ovr_q;
   rx_sync u_sync (
      .clk(clk),
      .rst(rst),
      .async_i(RX),
      .sync_o(rx_s),
      .fall_o(fall)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         baud_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         data_q <= '0;
         rdy_q <= 1'b0;
         frm_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         frm_q <= 1'b0;
         if (clr_rdy) begin
            rdy_q <= 1'b0;
            ovr_q <= 1'b0;
         end
         case (state_q)
            IDLE:
               if (fall) begin
                  baud_q <= '0;
                  bit_q <= '0;
                  state_q <= START;
               end
            START:
               if (baud_q == HALF_LAST) begin
                  baud_q <= '0;
                  state_q <= rx_s ? IDLE : DATA;
               end else baud_q <= baud_q + 1'b1;
            DATA:
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == BITS_LAST) state_q <= STOP;
               end else baud_q <= baud_q + 1'b1;
            STOP:
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  bit_q <= '0;
                  state_q <= IDLE;
                  if (rx_s) begin
                     data_q <= shift_q;
                     rdy_q <= 1'b1;
                     // a same-cycle clr_rdy consumes the old byte, so no overrun
                     if (rdy_q && !clr_rdy) ovr_q <= 1'b1;
                  end else frm_q <= 1'b1;
               end else baud_q <= baud_q + 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   assign rx_data = data_q;
   assign rdy = rdy_q;
   assign frm_err = frm_q;
   assign ovr_err = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed frames.
module tb_uart_rx;
   typedef struct {
      bit ferr;
      logic [7:0] data;
      bit rdy;
      bit ovr;
      int cyc;
   } exp_t;
   logic clk, rst, RX, clr_rdy;
   logic [7:0] rx_data;
   logic rdy, frm_err, ovr_err;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic m_rdy = 1'b0;
   logic m_ovr = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic rdy_p = 1'b0;
   logic [7:0] data_p = 8'h00;
   uart_rx dut (
      .clk(clk),
      .rst(rst),
      .RX(RX),
      .clr_rdy(clr_rdy),
      .rx_data(rx_data),
      .rdy(rdy),
      .frm_err(frm_err),
      .ovr_err(ovr_err)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at cyc %0d", name, act, exp, cyc);
      end
   endtask
   // drives n cycles of a frame; clr_rdy is high during cycle clr_at of the frame
   task automatic drive(input logic [7:0] d, input logic stop, input int clr_at, input int n, input bit push);
      logic [9:0] fr;
      exp_t e;
      fr = {stop, d, 1'b0};
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         RX = fr[i/44];
         clr_rdy = (i == clr_at);
         if (i == 0 && push) begin
            if (clr_at == 420) begin
               m_rdy = 1'b0;
               m_ovr = 1'b0;
            end
            if (stop) begin
               m_ovr = m_ovr | m_rdy;
               m_rdy = 1'b1;
               m_data = d;
            end
            e.ferr = !stop;
            e.data = m_data;
            e.rdy = m_rdy;
            e.ovr = m_ovr;
            e.cyc = cyc + 421;
            sb.push_back(e);
            if (clr_at == 425) begin
               m_rdy = 1'b0;
               m_ovr = 1'b0;
            end
         end
      end
      clr_rdy = 1'b0;
   endtask
   task automatic send(input logic [7:0] d, input logic stop, input int clr_at);
      drive(d, stop, clr_at, 440, 1'b1);
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (frm_err || (rdy && (!rdy_p || rx_data != data_p)))) begin
         if (sb.size() == 0) chk("unexpected_event", 1, 0);
         else begin
            e = sb.pop_front();
            chk("frm_err", int'(frm_err), int'(e.ferr));
            chk("rx_data", int'(rx_data), int'(e.data));
            chk("rdy", int'(rdy), int'(e.rdy));
            chk("ovr_err", int'(ovr_err), int'(e.ovr));
            checks++;
            if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
               errors++;
               $display("FAIL latency act=%0d exp=%0d", cyc, e.cyc);
            end
         end
      end
      rdy_p = rdy;
      data_p = rx_data;
   end
   initial begin
      rst = 1'b1;
      RX = 1'b1;
      clr_rdy = 1'b0;
      idle(3);
      chk("rst_data", int'(rx_data), 0);
      chk("rst_rdy", int'(rdy), 0);
      chk("rst_frm", int'(frm_err), 0);
      chk("rst_ovr", int'(ovr_err), 0);
      rst = 1'b0;
      idle(5);
      send(8'hA5, 1'b1, 425);
      idle(20);
      chk("a5_cleared", int'(rdy), 0);
      @(posedge clk);
      #1 RX = 1'b0;
      idle(10);
      RX = 1'b1;
      idle(100);
      chk("glitch_rdy", int'(rdy), 0);
      chk("glitch_ovr", int'(ovr_err), 0);
      send(8'h00, 1'b1, 425);
      send(8'hFF, 1'b1, 425);
      send(8'h3C, 1'b1, 425);
      idle(20);
      send(8'h55, 1'b0, -1);
      idle(300);
      chk("held_low_rdy", int'(rdy), 0);
      chk("held_low_data", int'(rx_data), 'h3C);
      RX = 1'b1;
      idle(50);
      send(8'h12, 1'b1, -1);
      send(8'h34, 1'b1, -1);
      idle(20);
      clr_rdy = 1'b1;
      idle(1);
      clr_rdy = 1'b0;
      m_rdy = 1'b0;
      m_ovr = 1'b0;
      chk("clr_rdy", int'(rdy), 0);
      chk("clr_ovr", int'(ovr_err), 0);
      send(8'h56, 1'b1, -1);
      send(8'h78, 1'b1, 420);
      idle(20);
      chk("simul_rdy", int'(rdy), 1);
      chk("simul_ovr", int'(ovr_err), 0);
      chk("sb_empty_pre_rst", sb.size(), 0);
      drive(8'h9A, 1'b1, -1, 240, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_data", int'(rx_data), 0);
      chk("arst_rdy", int'(rdy), 0);
      chk("arst_frm", int'(frm_err), 0);
      chk("arst_ovr", int'(ovr_err), 0);
      m_rdy = 1'b0;
      m_ovr = 1'b0;
      m_data = 8'h00;
      RX = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(10);
      send(8'hC3, 1'b1, -1);
      for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
      idle(5);
      chk("sb_drain", sb.size(), 0);
      chk("final_data", int'(rx_data), 'hC3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
